// File: rtl/ir_nec_rx.sv
// NEC IR receiver: leader/bit window timing, complement check, pulse outputs.
// Optional key-held repeat support enabled by defining IR_REPEAT_EN.
module ir_nec_rx #(
  parameter int CNT_W    = 9,
  parameter int LEAD_LO  = 256,
  parameter int LEAD_HI  = 128,
  parameter int RPT_HI   = 64,
  parameter int BIT0     = 32,
  parameter int BIT1     = 64,
  parameter int LEAD_TOL = 40,
  parameter int BIT_TOL  = 10,
  parameter int ADDR_CHK = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ir,
  output logic [7:0] addr,
  output logic [7:0] key_code,
  output logic       valid,
  output logic       rpt,
  output logic       err,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_LLO  = 4'b0010,
    S_LHI  = 4'b0100,
    S_DATA = 4'b1000
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic in_win(
    input int c,
    input int n,
    input int t
  );
    return (c > n - t) && (c < n + t);
  endfunction

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       bit_q, bit_d;
  logic [31:0]      sr_q, sr_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       key_q, key_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
`ifdef IR_REPEAT_EN
  logic             rpt_q, rpt_d;
  logic             held_q, held_d;
`endif

  logic        fall, rise, tmo;
  logic        w_llo, w_lhi, w_rpt, w_b0, w_b1;
  logic [31:0] word;
  logic        word_ok;
  int          cnt_i;

  assign fall  = s2_q & ~s1_q;
  assign rise  = ~s2_q & s1_q;
  assign tmo   = (cnt_q == CNT_MAX);
  assign cnt_i = int'(cnt_q);

  assign w_llo = in_win(cnt_i, LEAD_LO, LEAD_TOL);
  assign w_lhi = in_win(cnt_i, LEAD_HI, LEAD_TOL);
  assign w_rpt = in_win(cnt_i, RPT_HI, BIT_TOL);
  assign w_b0  = in_win(cnt_i, BIT0, BIT_TOL);
  assign w_b1  = in_win(cnt_i, BIT1, BIT_TOL);

  assign word    = {w_b1, sr_q[31:1]};
  assign word_ok = (word[31:24] == ~word[23:16]) &&
                   ((ADDR_CHK == 0) ||
                    (word[15:8] == ~word[7:0]));

  // Two-flop synchroniser inputs
  always_comb begin
    s1_d = ir;
    s2_d = s1_q;
  end

  // Synchroniser registers, idle-high after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  // Next-state, counter, shift register and pulse logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    addr_d  = addr_q;
    key_d   = key_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
`ifdef IR_REPEAT_EN
    rpt_d   = 1'b0;
    held_d  = held_q;
`endif
    if (state_q != S_IDLE && !tmo) begin
      cnt_d = cnt_q + 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = S_LLO;
          bit_d   = '0;
        end
      end
      S_LLO: begin
        if (rise) begin
          cnt_d = '0;
          if (w_llo) begin
            state_d = S_LHI;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_LHI: begin
        if (fall) begin
          cnt_d = '0;
          if (w_lhi) begin
            state_d = S_DATA;
            bit_d   = '0;
          end else if (w_rpt) begin
            state_d = S_IDLE;
`ifdef IR_REPEAT_EN
            if (held_q) begin
              rpt_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
`else
            err_d = 1'b1;
`endif
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (fall) begin
          cnt_d = '0;
          if (w_b0 || w_b1) begin
            sr_d  = word;
            bit_d = bit_q + 5'd1;
            if (bit_q == 5'd31) begin
              state_d = S_IDLE;
              if (word_ok) begin
                addr_d  = word[7:0];
                key_d   = word[23:16];
                valid_d = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
`ifdef IR_REPEAT_EN
    if (valid_d) begin
      held_d = 1'b1;
    end else if (err_d) begin
      held_d = 1'b0;
    end
`endif
  end

  // Decoder state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      addr_q  <= 8'h00;
      key_q   <= 8'hC0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef IR_REPEAT_EN
      rpt_q   <= 1'b0;
      held_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      addr_q  <= addr_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      err_q   <= err_d;
`ifdef IR_REPEAT_EN
      rpt_q   <= rpt_d;
      held_q  <= held_d;
`endif
    end
  end

  assign addr     = addr_q;
  assign key_code = key_q;
  assign valid    = valid_q;
  assign err      = err_q;
  assign busy     = (state_q != S_IDLE);
`ifdef IR_REPEAT_EN
  assign rpt      = rpt_q;
`else
  assign rpt      = 1'b0;
`endif

endmodule
